// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: parses Note-On/Note-Off on one MIDI channel and allocates
// voice slots in a downstream note register file. It emits one-cycle writes
// (addr/din/write_en) and sweeps every slot to zero after reset, because the
// register file has no reset of its own.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, a Note-On that
// finds no free slot overwrites the slot at a round-robin steal pointer.
// When it is undefined, such a Note-On is dropped.
module midi_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int CHANNEL    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  midi_byte,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [4:0]  addr,
    output logic [13:0] din,
    output logic        write_en,
    output logic        dropped
);

    typedef enum logic [2:0] {
        CLEAR, STATUS, DATA1, DATA2, SEARCH, WRITE, DROP
    } state_t;

    localparam logic [5:0] NV   = 6'(NUM_VOICES);
    localparam logic [5:0] LAST = 6'(NUM_VOICES - 1);
    localparam logic [3:0] CH   = 4'(CHANNEL);

    state_t      state, state_d;
    logic [5:0]  idx, idx_d;          // clear-sweep index / search index
    logic        rs_valid, rs_valid_d; // running status holds a note message
    logic        rs_on, rs_on_d;       // running status is Note-On (else Note-Off)
    logic [6:0]  note, note_d;
    logic [6:0]  vel, vel_d;

    logic        wr_en_d, dropped_d;
    logic [4:0]  addr_d;
    logic [13:0] din_d;

    // Shadow copy of what each slot holds; sized for the 5-bit address space.
    logic [31:0] act;
    logic [6:0]  snote [32];
    logic        sh_we, sh_act;
    logic [4:0]  sh_idx;

`ifdef VOICE_STEAL_EN
    logic [4:0]  steal_ptr;
    logic        steal_inc;
`endif

    logic        take, is_rt, is_note, on_eff, hit;
    logic [4:0]  slot;

    // Byte acceptance and message classification.
    assign byte_ready = (state == STATUS) || (state == DATA1) || (state == DATA2);
    assign take       = byte_valid && byte_ready;
    assign is_rt      = (midi_byte >= 8'hF8);
    assign is_note    = (midi_byte[7:5] == 3'b100) && (midi_byte[3:0] == CH);
    assign on_eff     = rs_on && (vel != 7'd0);
    assign slot       = idx[4:0];
    assign hit        = on_eff ? !act[slot] : (act[slot] && (snote[slot] == note));

    // Next-state, parser latches and next values of the registered outputs.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        rs_valid_d = rs_valid;
        rs_on_d    = rs_on;
        note_d     = note;
        vel_d      = vel;
        wr_en_d    = 1'b0;
        dropped_d  = 1'b0;
        addr_d     = addr;
        din_d      = din;
        sh_we      = 1'b0;
        sh_act     = 1'b0;
        sh_idx     = '0;
`ifdef VOICE_STEAL_EN
        steal_inc  = 1'b0;
`endif
        case (state)
            CLEAR: begin
                if (idx == NV) begin
                    idx_d   = '0;
                    state_d = STATUS;
                end else begin
                    wr_en_d = 1'b1;
                    addr_d  = idx[4:0];
                    din_d   = '0;
                    idx_d   = idx + 6'd1;
                end
            end
            STATUS, DATA1, DATA2: begin
                if (take && !is_rt) begin
                    if (midi_byte[7]) begin
                        // Any status byte (re)starts parsing, even mid-message.
                        if (is_note) begin
                            rs_valid_d = 1'b1;
                            rs_on_d    = midi_byte[4];
                            state_d    = DATA1;
                        end else begin
                            rs_valid_d = 1'b0;
                            state_d    = STATUS;
                        end
                    end else if (state == DATA2) begin
                        vel_d   = midi_byte[6:0];
                        idx_d   = '0;
                        state_d = SEARCH;
                    end else if (state == DATA1 || rs_valid) begin
                        note_d  = midi_byte[6:0];
                        state_d = DATA2;
                    end
                end
            end
            SEARCH: begin
                if (hit) begin
                    state_d = WRITE;
                    wr_en_d = 1'b1;
                    addr_d  = slot;
                    din_d   = on_eff ? {1'b1, vel[6:1], note} : 14'd0;
                    sh_we   = 1'b1;
                    sh_idx  = slot;
                    sh_act  = on_eff;
                end else if (idx == LAST) begin
`ifdef VOICE_STEAL_EN
                    if (on_eff) begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        addr_d    = steal_ptr;
                        din_d     = {1'b1, vel[6:1], note};
                        sh_we     = 1'b1;
                        sh_idx    = steal_ptr;
                        sh_act    = 1'b1;
                        steal_inc = 1'b1;
                    end else begin
                        state_d   = DROP;
                        dropped_d = 1'b1;
                    end
`else
                    state_d   = DROP;
                    dropped_d = 1'b1;
`endif
                end else begin
                    idx_d = idx + 6'd1;
                end
            end
            WRITE:   state_d = STATUS;
            DROP:    state_d = STATUS;
            default: state_d = CLEAR;
        endcase
    end

    // State, parser and output registers; reset restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= CLEAR;
            idx      <= '0;
            rs_valid <= 1'b0;
            rs_on    <= 1'b0;
            note     <= '0;
            vel      <= '0;
            write_en <= 1'b0;
            dropped  <= 1'b0;
            addr     <= '0;
            din      <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            rs_valid <= rs_valid_d;
            rs_on    <= rs_on_d;
            note     <= note_d;
            vel      <= vel_d;
            write_en <= wr_en_d;
            dropped  <= dropped_d;
            addr     <= addr_d;
            din      <= din_d;
        end
    end

    // Shadow slot state: wiped by reset and by the clear sweep, else follows writes.
    always_ff @(posedge clk) begin
        if (!reset_n || state == CLEAR) begin
            act <= '0;
            for (int i = 0; i < 32; i++) snote[i] <= '0;
        end else if (sh_we) begin
            act[sh_idx]   <= sh_act;
            snote[sh_idx] <= note;
        end
    end

`ifdef VOICE_STEAL_EN
    // Round-robin steal pointer, advanced after each stolen slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            steal_ptr <= '0;
        end else if (steal_inc) begin
            steal_ptr <= (steal_ptr == LAST[4:0]) ? 5'd0 : steal_ptr + 5'd1;
        end
    end
`endif

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: directed scenarios plus random note traffic,
// checked against a slot-level reference model of the allocator.
module tb_midi_voice_alloc;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  midi_byte = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [4:0]  addr;
    logic [13:0] din;
    logic        write_en;
    logic        dropped;

    midi_voice_alloc #(.NUM_VOICES(NV), .CHANNEL(0)) dut (
        .clk(clk), .reset_n(reset_n), .midi_byte(midi_byte),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .addr(addr),
        .din(din), .write_en(write_en), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Register file image as seen through the write port, plus event counts.
    logic [13:0] rf [NV];
    int wcount = 0;
    int dcount = 0;
    always @(negedge clk) begin
        if (write_en) begin
            if (int'(addr) < NV) rf[addr] = din;
            wcount++;
        end
        if (dropped) dcount++;
    end

    // Reference model: slot contents and steal pointer.
    bit          m_act  [NV];
    logic [6:0]  m_note [NV];
    logic [13:0] m_img  [NV];
    int          m_steal = 0;
    int          t_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 0; m_note[i] = '0; m_img[i] = '0;
        end
        m_steal = 0;
    endtask

    // Assert reset, check idle outputs, release and check the clear sweep.
    task automatic do_reset();
        int r0;
        @(negedge clk);
        reset_n = 1'b0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", 32'(byte_ready), 0);
        chk("rst_write_en", 32'(write_en), 0);
        chk("rst_dropped", 32'(dropped), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_din", 32'(din), 0);
        reset_n = 1'b1;
        r0 = cyc;
        model_clear();
        for (int c = r0 + 1; c <= r0 + NV + 1; c++) begin
            @(negedge clk);
            chk("clr_write_en", 32'(write_en), 32'(c <= r0 + NV));
            chk("clr_ready", 32'(byte_ready), 32'(c == r0 + NV + 1));
            if (c <= r0 + NV) begin
                chk("clr_addr", 32'(addr), 32'(c - r0 - 1));
                chk("clr_din", 32'(din), 0);
            end
        end
    endtask

    // Offer one byte; waits a bounded time for byte_ready.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            chk("ready_timeout", 0, 1);
        end else begin
            midi_byte  = b;
            byte_valid = 1'b1;
            t_acc      = cyc;
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    // Predict the outcome of a completed message and check the cycles after it.
    task automatic expect_msg(input bit on, input logic [6:0] n, input logic [6:0] v, input int t);
        bit on_eff, wr;
        int k, slot, evt;
        logic [13:0] d;
        on_eff = on && (v != 0);
        k = -1;
        wr = 0;
        slot = 0;
        for (int i = 0; i < NV; i++)
            if (k < 0 && (on_eff ? !m_act[i] : (m_act[i] && m_note[i] == n))) k = i;
        if (k >= 0) begin
            wr = 1; slot = k; evt = t + 2 + k;
        end else begin
            evt = t + NV + 1;
`ifdef VOICE_STEAL_EN
            if (on_eff) begin
                wr = 1; slot = m_steal; m_steal = (m_steal + 1) % NV;
            end
`endif
        end
        d = on_eff ? {1'b1, v[6:1], n} : 14'h0;
        if (wr) begin
            m_act[slot] = on_eff; m_note[slot] = n; m_img[slot] = d;
        end
        for (int c = t + 1; c <= evt + 1; c++) begin
            chk("msg_write_en", 32'(write_en), 32'(wr && c == evt));
            chk("msg_dropped", 32'(dropped), 32'(!wr && c == evt));
            chk("msg_ready", 32'(byte_ready), 32'(c == evt + 1));
            if (wr && c == evt) begin
                chk("msg_addr", 32'(addr), 32'(slot));
                chk("msg_din", 32'(din), 32'(d));
            end
            if (c < evt + 1) @(negedge clk);
        end
    endtask

    task automatic note_msg(input logic [7:0] st, input bit use_st, input logic [6:0] n, input logic [6:0] v);
        if (use_st) send_byte(st);
        send_byte({1'b0, n});
        send_byte({1'b0, v});
        expect_msg(st[4], n, v, t_acc);
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < NV; i++) chk(tag, 32'(rf[i]), 32'(m_img[i]));
    endtask

    initial begin
        int w0, d0;
        bit rs_ok, rs_on, on, use_rs;
        logic [6:0] n, v;

        // Reset and clear sweep.
        do_reset();
        check_image("img_after_clear");

        // Basic Note-On into slot 0.
        note_msg(8'h90, 1, 7'h3C, 7'h64);

        // Reset mid-message abandons it and restarts the sweep.
        send_byte(8'h90);
        send_byte(8'h3C);
        do_reset();
        check_image("img_after_midreset");

        // Running status, then explicit Note-Off.
        note_msg(8'h90, 1, 7'h3C, 7'h40);
        note_msg(8'h90, 0, 7'h3E, 7'h40);
        note_msg(8'h80, 1, 7'h3C, 7'h00);

        // Note-On velocity 0 with no matching slot is a dropped Note-Off.
        w0 = wcount; d0 = dcount;
        note_msg(8'h90, 1, 7'h40, 7'h00);
        chk("vel0_no_write", 32'(wcount - w0), 0);
        chk("vel0_one_drop", 32'(dcount - d0), 1);

        // Five Note-Ons into four slots.
        do_reset();
        note_msg(8'h90, 1, 7'h50, 7'h11);
        for (int i = 1; i < 5; i++) note_msg(8'h90, 0, 7'(7'h50 + i), 7'h22);
        check_image("img_after_overflow");

        // Wrong channel produces nothing; real-time byte inside a message is ignored.
        do_reset();
        w0 = wcount; d0 = dcount;
        send_byte(8'h91);
        send_byte(8'h3C);
        send_byte(8'h64);
        repeat (NV + 4) @(negedge clk);
        chk("wrongch_no_write", 32'(wcount - w0), 0);
        chk("wrongch_no_drop", 32'(dcount - d0), 0);
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF8);
        send_byte(8'h64);
        expect_msg(1, 7'h3C, 7'h64, t_acc);

        // Random note traffic over a small note set so Note-Offs often match.
        rs_ok = 1; rs_on = 1;
        for (int m = 0; m < 60; m++) begin
            on = ($urandom_range(0, 2) != 0);
            n  = 7'(7'h30 + $urandom_range(0, 3));
            v  = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            use_rs = rs_ok && (rs_on == on) && ($urandom_range(0, 1) == 1);
            if (!use_rs) send_byte(on ? 8'h90 : 8'h80);
            if ($urandom_range(0, 3) == 0) send_byte(8'hF8);
            send_byte({1'b0, n});
            if ($urandom_range(0, 3) == 0) send_byte(8'hF8);
            send_byte({1'b0, v});
            expect_msg(on, n, v, t_acc);
            rs_ok = 1; rs_on = on;
            if ($urandom_range(0, 9) == 0) begin
                // Unrelated status byte kills running status.
                send_byte(8'hB0);
                send_byte(8'h07);
                rs_ok = 0;
            end
        end
        check_image("img_after_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
